// File: rtl/block_check_pkg.sv
// ============================================================================
// block_check_pkg : shared types and helpers for the block checker scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package block_check_pkg;

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    STREAM = 7'b0000010,
    FLUSH  = 7'b0000100,
    SAMPLE = 7'b0001000,
    DROP   = 7'b0010000,
    RESP   = 7'b0100000,
    CLEAR  = 7'b1000000
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int c_sat_w = 32;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  function automatic logic [c_sat_w-1:0] sat_inc(input logic [c_sat_w-1:0] value,
                                                 input int width);
    logic [c_sat_w-1:0] lim;
    lim = (width >= c_sat_w) ? '1 : ((c_sat_w'(1) << width) - c_sat_w'(1));
    return (value >= lim) ? value : value + c_sat_w'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_check_scheduler_if.sv
// ============================================================================
// block_check_scheduler_if : requester, checker and response signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface block_check_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
);
  localparam int c_idw = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              chk_valid;
  logic [7:0]        chk_data;
  logic              chk_clr;
  logic              chk_result;
  logic              resp_valid;
  logic              resp_ready;
  logic [c_idw-1:0]  resp_id;
  logic              resp_ok;
  logic              resp_err;
  logic [CNTW-1:0]   ok_cnt;
  logic [CNTW-1:0]   bad_cnt;

  modport master (
    input  req_valid, req_data, req_last, chk_result, resp_ready,
    output req_ready, chk_valid, chk_data, chk_clr,
           resp_valid, resp_id, resp_ok, resp_err, ok_cnt, bad_cnt
  );

  modport slave (
    output req_valid, req_data, req_last, chk_result, resp_ready,
    input  req_ready, chk_valid, chk_data, chk_clr,
           resp_valid, resp_id, resp_ok, resp_err, ok_cnt, bad_cnt
  );

endinterface

`default_nettype wire

// File: rtl/block_check_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching from i_ptr+1 upward
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt_onehot,
  output logic [$clog2(NREQ)-1:0] o_gnt_idx,
  output logic                    o_gnt_any
);
  localparam int c_idw = $clog2(NREQ);

  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_gnt_any    = 1'b0;
    // Offset NREQ wraps back to i_ptr itself, so it has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_gnt_any && i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_gnt_any = 1'b1;
        o_gnt_idx = c_idw'((int'(i_ptr) + k) % NREQ);
        o_gnt_onehot[(int'(i_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_check_scheduler.sv
// ============================================================================
// block_check_scheduler : grants whole messages round-robin to one shared
// block checker, flushes with a space, and reports the sampled verdict.
// Revision 1.0
// ============================================================================
`default_nettype none

module block_check_scheduler
  import block_check_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MAXLEN = 64,
  parameter int CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  block_check_scheduler_if.master bus
);
  localparam int c_idw  = $clog2(NREQ);
  localparam int c_lenw = $clog2(MAXLEN + 1);
  localparam logic [c_lenw-1:0] c_len_last = c_lenw'(MAXLEN - 1);

  state_t             r_state;
  logic [c_idw-1:0]   r_ptr;
  logic [c_idw-1:0]   r_grant;
  logic [NREQ-1:0]    r_grant_oh;
  logic [c_lenw-1:0]  r_len;
  logic               r_resp_valid;
  logic               r_resp_ok;
  logic               r_resp_err;
  logic [c_idw-1:0]   r_resp_id;
  logic [CNTW-1:0]    r_ok_cnt;
  logic [CNTW-1:0]    r_bad_cnt;

  logic [NREQ-1:0]    w_gnt_onehot;
  logic [c_idw-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic [NREQ-1:0]    w_req_ready;
  logic               w_chk_valid;
  logic [7:0]         w_chk_data;
  logic               w_sel_valid;
  logic [7:0]         w_sel_data;
  logic               w_last;
  logic               w_accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req        (bus.req_valid),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_any    (w_gnt_any)
  );

  assign w_sel_valid = |(bus.req_valid & r_grant_oh);
  assign w_sel_data  = bus.req_data[int'(r_grant)*8 +: 8];
  assign w_last      = bus.req_last[r_grant];
  assign w_accept    = |(w_req_ready & bus.req_valid);

  always_comb begin
    w_req_ready = '0;
    w_chk_valid = 1'b0;
    w_chk_data  = '0;
    case (r_state)
      STREAM: begin
        w_req_ready = r_grant_oh;
        w_chk_valid = w_sel_valid;
        w_chk_data  = w_sel_data;
      end
      FLUSH: begin
        w_chk_valid = 1'b1;
        w_chk_data  = ASCII_SPACE;
      end
      // Overlong message: keep draining chars but hide them from the checker.
      DROP:    w_req_ready = r_grant_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ptr        <= c_idw'(NREQ - 1);
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_len        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_ok    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_id    <= '0;
      r_ok_cnt     <= '0;
      r_bad_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_grant    <= w_gnt_idx;
            r_grant_oh <= w_gnt_onehot;
            r_ptr      <= w_gnt_idx;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_len <= r_len + c_lenw'(1);
            if (w_last)
              r_state <= FLUSH;
            else if (r_len == c_len_last)
              r_state <= DROP;
          end
        end
        FLUSH: r_state <= SAMPLE;
        SAMPLE: begin
          r_resp_ok    <= bus.chk_result;
          r_resp_err   <= 1'b0;
          r_resp_id    <= r_grant;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        DROP: begin
          if (w_accept && w_last) begin
            r_resp_ok    <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_id    <= r_grant;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            if (r_resp_ok)
              r_ok_cnt <= CNTW'(sat_inc(32'(r_ok_cnt), CNTW));
            else
              r_bad_cnt <= CNTW'(sat_inc(32'(r_bad_cnt), CNTW));
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_len      <= '0;
          r_grant    <= '0;
          r_grant_oh <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.chk_valid  = w_chk_valid;
  assign bus.chk_data   = w_chk_data;
  assign bus.chk_clr    = ~reset | (r_state == CLEAR);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_ok    = r_resp_ok;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_id    = r_resp_id;
  assign bus.ok_cnt     = r_ok_cnt;
  assign bus.bad_cnt    = r_bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_block_check_scheduler.sv
// ============================================================================
// tb_block_check_scheduler : two scheduler instances (MAXLEN 64 and 8) driven
// by message tables, with a behavioural begin/end checker and a scoreboard.
// ============================================================================
`default_nettype none

module tb_block_check_scheduler;
  localparam int NREQ = 4;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_check_scheduler_if #(.NREQ(NREQ), .CNTW(CNTW)) bus_a ();
  block_check_scheduler_if #(.NREQ(NREQ), .CNTW(CNTW)) bus_b ();

  block_check_scheduler #(.NREQ(NREQ), .MAXLEN(64), .CNTW(CNTW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  block_check_scheduler #(.NREQ(NREQ), .MAXLEN(8), .CNTW(CNTW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Behavioural checker: space-separated words, begin/end nesting, case-insensitive.
  typedef struct packed {
    logic [39:0] word;
    logic [3:0]  wlen;
    logic [7:0]  depth;
    logic        err;
  } chk_t;

  chk_t st_a, st_b;

  function automatic chk_t chk_step(chk_t s, logic [7:0] c);
    chk_t n;
    logic [7:0] lc;
    n  = s;
    lc = (c >= "A" && c <= "Z") ? (c | 8'h20) : c;
    if (c == 8'h20) begin
      if (s.wlen == 4'd5 && s.word == "begin")
        n.depth = s.depth + 8'd1;
      else if (s.wlen == 4'd3 && s.word[23:0] == "end") begin
        if (s.depth == 8'd0) n.err = 1'b1;
        else n.depth = s.depth - 8'd1;
      end
      n.word = '0;
      n.wlen = '0;
    end else begin
      n.word = {s.word[31:0], lc};
      if (s.wlen != 4'hf) n.wlen = s.wlen + 4'd1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (bus_a.chk_clr) st_a <= '0;
    else if (bus_a.chk_valid) st_a <= chk_step(st_a, bus_a.chk_data);
    if (bus_b.chk_clr) st_b <= '0;
    else if (bus_b.chk_valid) st_b <= chk_step(st_b, bus_b.chk_data);
  end
  assign bus_a.chk_result = ~st_a.err && (st_a.depth == 8'd0);
  assign bus_b.chk_result = ~st_b.err && (st_b.depth == 8'd0);

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  typedef struct {
    int id;
    bit ok;
    bit err;
  } exp_t;

  exp_t q_a[$], q_b[$];
  logic [7:0] log_a[$], log_b[$];
  int exp_ok_a, exp_bad_a, exp_ok_b, exp_bad_b;
  int clr_a, clr_b, multi_ready;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_ok_a = 0; exp_bad_a = 0;
    end else begin
      if (bus_a.chk_valid) log_a.push_back(bus_a.chk_data);
      if (bus_a.chk_clr) clr_a++;
      if ($countones(bus_a.req_ready) > 1) multi_ready++;
      if (bus_a.resp_valid && bus_a.resp_ready) begin
        check("a_resp_expected", 64'(q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          check("a_resp_id", bus_a.resp_id, e.id);
          check("a_resp_ok", bus_a.resp_ok, e.ok);
          check("a_resp_err", bus_a.resp_err, e.err);
          if (e.ok) exp_ok_a++; else exp_bad_a++;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_ok_b = 0; exp_bad_b = 0;
    end else begin
      if (bus_b.chk_valid) log_b.push_back(bus_b.chk_data);
      if (bus_b.chk_clr) clr_b++;
      if (bus_b.resp_valid && bus_b.resp_ready) begin
        check("b_resp_expected", 64'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("b_resp_id", bus_b.resp_id, e.id);
          check("b_resp_ok", bus_b.resp_ok, e.ok);
          check("b_resp_err", bus_b.resp_err, e.err);
          if (e.ok) exp_ok_b++; else exp_bad_b++;
        end
      end
    end
  end

  task automatic drive(int d, int id, logic v, logic [7:0] c, logic l);
    if (d == 0) begin
      bus_a.req_valid[id] = v; bus_a.req_data[id*8 +: 8] = c; bus_a.req_last[id] = l;
    end else begin
      bus_b.req_valid[id] = v; bus_b.req_data[id*8 +: 8] = c; bus_b.req_last[id] = l;
    end
  endtask

  task automatic send_char(int d, int id, logic [7:0] c, logic l);
    int   b   = 0;
    logic got = 1'b0;
    drive(d, id, 1'b1, c, l);
    while (!got && b < 200) begin
      @(negedge clk);
      got = (d == 0) ? bus_a.req_ready[id] : bus_b.req_ready[id];
      @(posedge clk); #1;
      b++;
    end
    check("char_accepted", got, 1);
  endtask

  task automatic send_msg(int d, int id, string m, bit toggle);
    for (int i = 0; i < m.len(); i++) begin
      if (toggle && (i % 2 == 1)) begin
        drive(d, id, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
      end
      send_char(d, id, m[i], (i == m.len() - 1));
    end
    drive(d, id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_done();
    int b = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", 64'(q_a.size() + q_b.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Checker must see the message chars then one space, or only MAXLEN chars on abort.
  task automatic check_stream(int d, string m, bit err);
    logic [7:0] lq[$];
    logic [7:0] ec;
    int n, bad;
    if (d == 0) lq = log_a; else lq = log_b;
    n   = err ? ((d == 0) ? 64 : 8) : m.len() + 1;
    bad = -1;
    check("chk_stream_len", 64'(lq.size()), 64'(n));
    for (int i = 0; i < n && i < lq.size(); i++) begin
      ec = (i < m.len()) ? m[i] : 8'h20;
      if (lq[i] !== ec && bad < 0) bad = i;
    end
    check("chk_stream_first_bad_index", 64'(bad), 64'(-1));
  endtask

  task automatic check_rst(string tag, logic [NREQ-1:0] rr, logic cv, logic [7:0] cd,
                           logic clr, logic rv, logic ok, logic er, logic [1:0] id,
                           logic [CNTW-1:0] okc, logic [CNTW-1:0] badc);
    check({tag, "_req_ready"}, rr, 0);
    check({tag, "_chk_valid"}, cv, 0);
    check({tag, "_chk_data"}, cd, 0);
    check({tag, "_chk_clr"}, clr, 1);
    check({tag, "_resp_fields"}, {rv, ok, er, id}, 0);
    check({tag, "_ok_cnt"}, okc, 0);
    check({tag, "_bad_cnt"}, badc, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int    d;
    int    id;
    string msg;
    bit    ok;
    bit    err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int okb;
    int b;
    vecs[0] = '{0, 0, "begin end", 1'b1, 1'b0};
    vecs[1] = '{0, 1, "end begin", 1'b0, 1'b0};
    vecs[2] = '{0, 2, "x", 1'b1, 1'b0};
    vecs[3] = '{0, 3, "begin begin end end", 1'b1, 1'b0};
    vecs[4] = '{1, 3, "beginbeginend", 1'b0, 1'b1};
    vecs[5] = '{1, 1, "begin end", 1'b0, 1'b1};
    vecs[6] = '{1, 2, "ab cd ef", 1'b1, 1'b0};

    reset = 1'b0;
    bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_last = '0; bus_a.resp_ready = 1'b1;
    bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.req_last = '0; bus_b.resp_ready = 1'b1;
    clr_a = 0; clr_b = 0; multi_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check_rst("a_reset", bus_a.req_ready, bus_a.chk_valid, bus_a.chk_data, bus_a.chk_clr,
              bus_a.resp_valid, bus_a.resp_ok, bus_a.resp_err, bus_a.resp_id,
              bus_a.ok_cnt, bus_a.bad_cnt);
    check_rst("b_reset", bus_b.req_ready, bus_b.chk_valid, bus_b.chk_data, bus_b.chk_clr,
              bus_b.resp_valid, bus_b.resp_ok, bus_b.resp_err, bus_b.resp_id,
              bus_b.ok_cnt, bus_b.bad_cnt);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      log_a.delete(); log_b.delete(); clr_a = 0; clr_b = 0;
      if (vecs[i].d == 0) q_a.push_back('{vecs[i].id, vecs[i].ok, vecs[i].err});
      else                q_b.push_back('{vecs[i].id, vecs[i].ok, vecs[i].err});
      send_msg(vecs[i].d, vecs[i].id, vecs[i].msg, 1'b0);
      wait_done();
      check_stream(vecs[i].d, vecs[i].msg, vecs[i].err);
      check("clr_pulses", 64'((vecs[i].d == 0) ? clr_a : clr_b), 1);
    end
    check("a_ok_cnt", bus_a.ok_cnt, 64'(exp_ok_a));
    check("a_bad_cnt", bus_a.bad_cnt, 64'(exp_bad_a));
    check("b_ok_cnt", bus_b.ok_cnt, 64'(exp_ok_b));
    check("b_bad_cnt", bus_b.bad_cnt, 64'(exp_bad_b));

    // Stalled response with a requester that drops valid between chars.
    bus_a.resp_ready = 1'b0;
    okb = exp_ok_a;
    q_a.push_back('{0, 1'b1, 1'b0});
    send_msg(0, 0, "BEGIN END", 1'b1);
    b = 0;
    while (!bus_a.resp_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("hold_resp_valid_seen", bus_a.resp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_resp_valid", bus_a.resp_valid, 1);
      check("hold_resp_id", bus_a.resp_id, 0);
      check("hold_resp_ok", bus_a.resp_ok, 1);
      check("hold_ok_cnt", bus_a.ok_cnt, 64'(okb));
    end
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b1;
    wait_done();
    check("hold_ok_cnt_after", bus_a.ok_cnt, 64'(okb + 1));

    // Two simultaneous requesters right after reset: req0 first, then req2.
    do_reset();
    log_a.delete(); multi_ready = 0;
    q_a.push_back('{0, 1'b0, 1'b0});
    q_a.push_back('{2, 1'b0, 1'b0});
    fork
      send_msg(0, 0, "begin", 1'b0);
      send_msg(0, 2, "begin", 1'b0);
    join
    wait_done();
    check_stream(0, "begin begin", 1'b0);
    check("no_interleaved_ready", 64'(multi_ready), 0);
    check("rr_bad_cnt", bus_a.bad_cnt, 2);

    // Asynchronous reset in the middle of a message.
    send_char(0, 1, "b", 1'b0);
    send_char(0, 1, "e", 1'b0);
    send_char(0, 1, "g", 1'b0);
    drive(0, 1, 1'b0, 8'h00, 1'b0);
    #1 reset = 1'b0;
    #1;
    check_rst("a_midreset", bus_a.req_ready, bus_a.chk_valid, bus_a.chk_data, bus_a.chk_clr,
              bus_a.resp_valid, bus_a.resp_ok, bus_a.resp_err, bus_a.resp_id,
              bus_a.ok_cnt, bus_a.bad_cnt);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    log_a.delete();
    q_a.push_back('{0, 1'b1, 1'b0});
    send_msg(0, 0, "begin end", 1'b0);
    wait_done();
    check_stream(0, "begin end", 1'b0);
    check("post_reset_ok_cnt", bus_a.ok_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/block_check_scheduler.md
Name: block_check_scheduler

Overview:
- Shares one BlockChecker datapath between NREQ character-stream requesters. Each requester sends a message: ASCII chars, last char flagged.
- Grants whole messages round-robin and feeds the chars to the checker. Appends one terminating space, samples the checker verdict, reports it, then clears the checker for the next message.
- Sits between the text-source front ends and the checker instance.
- The checker advances only on cycles where chk_valid=1; the checker wrapper enforces this.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXLEN, 64, maximum chars per message before abort.
- CNTW, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  requester i presents a char.
- req_data  in  8*NREQ  char of requester i in bits [8i+7:8i].
- req_last  in  NREQ  char is the last of its message.
- req_ready  out  NREQ  char of requester i consumed this cycle.
- chk_valid  out  1  checker advance strobe.
- chk_data  out  8  char to checker.
- chk_clr  out  1  checker reset, active-high.
- chk_result  in  1  checker result output.
- resp_valid  out  1  verdict available.
- resp_ready  in  1  verdict accepted.
- resp_id  out  $clog2(NREQ)  requester the verdict belongs to.
- resp_ok  out  1  message balanced (checker result=1).
- resp_err  out  1  message aborted for exceeding MAXLEN.
- ok_cnt  out  CNTW  count of verdicts with resp_ok=1, saturating.
- bad_cnt  out  CNTW  count of verdicts with resp_ok=0, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr pointer=NREQ-1 (req0 has first priority), grant=0, len=0.
  - All outputs 0 except chk_clr=1.
  - chk_clr = ~reset | (state==CLEAR).
- IDLE: if any req_valid, pick the first requester at or after ptr+1 (wrapping). Register grant and ptr, go to STREAM next cycle. No char is consumed in IDLE.
- STREAM:
  - req_ready[g] = 1, where g is the granted index; all other req_ready = 0.
  - chk_valid = req_valid[g]; chk_data = req_data[g].
  - If req_valid[g]=0: chk_valid=0, checker holds, no timeout.
  - Each accepted char increments len.
  - Accepted char with req_last=1: go to FLUSH.
  - Accepted char with len==MAXLEN-1 and req_last=0: go to DROP.
- FLUSH: chk_valid=1, chk_data=8'h20 for one cycle; then SAMPLE.
- SAMPLE: capture resp_ok=chk_result, resp_err=0, resp_id=g; go to RESP.
- DROP:
  - req_ready[g]=1, chk_valid=0; chars are discarded until the req_last char is accepted.
  - Then set resp_ok=0, resp_err=1, resp_id=g; go to RESP.
- RESP: resp_valid=1, held stable until resp_ready=1.
  - On the handshake cycle, increment ok_cnt or bad_cnt (saturate at all-ones); go to CLEAR.
- CLEAR: chk_clr=1 for one cycle, len=0, grant cleared; go to IDLE.
- Latency: last char accepted at cycle t → FLUSH t+1, SAMPLE t+2, resp_valid high from t+3. Next grant possible no earlier than 2 cycles after the resp handshake.
- A requester keeps its grant for its entire message; requests from others wait. Requester-side valid deassertion mid-message is legal.
- A single-char message (req_last on the first char) is legal.
- Simultaneous req_valid: the rr order is strict, with ptr = last granted index.
- Reset mid-message: the message is lost with no verdict, the counters clear, and the checker is cleared via chk_clr.

Decomposition:
- Package block_check_pkg:
  - state enum (IDLE, STREAM, FLUSH, SAMPLE, DROP, RESP, CLEAR), one-hot;
  - ASCII_SPACE=8'h20;
  - saturating-increment function.
- Sub-module rr_arbiter (NREQ requests, ptr input, grant one-hot and index outputs, combinational). Reused by the planned multi-checker variant.

Test Plan:
- Reset, then req0 sends "begin end" (last on 'd'), resp_ready=1 → chk_data sequence is the 9 chars then 8'h20. resp_valid with resp_id=0, resp_ok=1, resp_err=0; ok_cnt=1; one chk_clr pulse afterwards.
- req1 sends "end begin" → resp_id=1, resp_ok=0; bad_cnt=1.
- req0 and req2 both valid in the same cycle after reset, each sending "begin" → req0 served first (resp_ok=0), then req2. Interleaving of req_ready never occurs.
- MAXLEN=8, req3 sends "beginbeginend" → chk_valid stays 0 after the 8th char. resp_err=1, resp_ok=0; all 13 chars are consumed.
- req0 toggles req_valid every other cycle while sending "BEGIN END", and resp_ready is held 0 for 5 cycles → resp_ok=1. resp_valid and resp_id remain stable for 5 cycles; the counter increments only on the handshake.
- Assert reset during STREAM of "begin" → all outputs 0 and chk_clr=1 immediately. A following "begin end" yields resp_ok=1.
